// File: rtl/sample_send_ctrl_pkg.sv
// Shared definitions for the sample read-back path: send FSM states, byte
// ordering and word-to-byte sizing helpers.
package sample_send_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        READ,
        MEM_WAIT,
        LOAD,
        SEND,
        TX_GAP,
        TX_WAIT,
        NEXT,
        DONE
    } sendState_t;

    // Words leave the serializer most-significant byte first.
    localparam bit MSB_FIRST = 1'b1;

    function automatic int unsigned nBytes(input int unsigned dataW);
        return dataW / 8;
    endfunction

    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sample_send_ctrl_if.sv
// Handshake bundle between the send controller, the main FSM, the sample RAM
// read port and the UART transmitter.
interface sample_send_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              iStart;
    logic [ADDR_W:0]   iCount;
    logic              oMemRead;
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] iMemData;
    logic              oTxStart;
    logic [7:0]        oTxData;
    logic              iTxBusy;
    logic              oBusy;
    logic              oDone;

    modport master (
        output iStart, iCount, iMemData, iTxBusy,
        input  oMemRead, oMemAddr, oTxStart, oTxData, oBusy, oDone
    );

    modport slave (
        input  iStart, iCount, iMemData, iTxBusy,
        output oMemRead, oMemAddr, oTxStart, oTxData, oBusy, oDone
    );

endinterface

// File: rtl/sample_send_ctrl_word_byte_serializer.sv
// Parallel-load word register that presents one byte at a time and shifts by
// a byte on each advance.
module word_byte_serializer
    import sample_send_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iLoad,
    input  logic              iAdvance,
    input  logic [DATA_W-1:0] iData,
    output logic [7:0]        oByte
);

    logic [DATA_W-1:0] shiftReg;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            shiftReg <= '0;
        end else if (iLoad) begin
            shiftReg <= iData;
        end else if (iAdvance) begin
            if (MSB_FIRST) shiftReg <= shiftReg << 8;
            else           shiftReg <= shiftReg >> 8;
        end
    end

    assign oByte = MSB_FIRST ? shiftReg[DATA_W-1 -: 8] : shiftReg[7:0];

endmodule

// File: rtl/sample_send_ctrl.sv
// Reads iCount sample words from address 0 upward and streams them, byte by
// byte, to the UART transmitter; pulses oDone when the last byte is through.
module sample_send_ctrl
    import sample_send_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic iClock,
    input  logic iReset,
    sample_send_ctrl_if.slave bus
);

    localparam int unsigned NBYTES = nBytes(DATA_W);
    localparam int unsigned IDX_W  = idxWidth(NBYTES);
    localparam int unsigned WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    sendState_t state, nextState;

    logic [ADDR_W:0]   countReg;
    logic [ADDR_W-1:0] addrReg;
    logic [IDX_W-1:0]  byteIdx;
    logic [WAIT_W-1:0] waitCnt;
    logic [7:0]        serByte;
    logic              lastByte;
    logic              lastWord;

    logic memReadD;
    logic txStartD;
    logic doneD;
    logic busyD;

    assign lastByte = (byteIdx == IDX_W'(NBYTES - 1));
    assign lastWord = ({1'b0, addrReg} == (countReg - (ADDR_W+1)'(1)));

    word_byte_serializer #(
        .DATA_W(DATA_W)
    ) serializer (
        .iClock  (iClock),
        .iReset  (iReset),
        .iLoad   (state == LOAD),
        .iAdvance((state == NEXT) && !lastByte),
        .iData   (bus.iMemData),
        .oByte   (serByte)
    );

    always_ff @(posedge iClock) begin
        if (iReset) state <= IDLE;
        else        state <= nextState;
    end

    // Outputs are registered from the current state, so every strobe trails
    // its state by one cycle; MEM_WAIT therefore spans the oMemRead cycle
    // plus MEM_LAT-1 further cycles, landing LOAD on the valid data.
    always_comb begin
        nextState = state;
        memReadD  = 1'b0;
        txStartD  = 1'b0;
        doneD     = 1'b0;
        busyD     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (bus.iStart) nextState = (bus.iCount == '0) ? DONE : READ;
            end
            READ: begin
                memReadD  = 1'b1;
                nextState = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (waitCnt == '0) nextState = LOAD;
            end
            LOAD: begin
                nextState = SEND;
            end
            SEND: begin
                if (!bus.iTxBusy) begin
                    txStartD  = 1'b1;
                    nextState = TX_GAP;
                end
            end
            TX_GAP: begin
                nextState = TX_WAIT;
            end
            TX_WAIT: begin
                if (!bus.iTxBusy) nextState = NEXT;
            end
            NEXT: begin
                if (!lastByte)     nextState = SEND;
                else if (lastWord) nextState = DONE;
                else               nextState = READ;
            end
            DONE: begin
                doneD     = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            countReg <= '0;
            addrReg  <= '0;
            byteIdx  <= '0;
            waitCnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        countReg <= bus.iCount;
                        addrReg  <= '0;
                    end
                end
                READ: begin
                    waitCnt <= WAIT_W'(MEM_LAT - 1);
                end
                MEM_WAIT: begin
                    if (waitCnt != '0) waitCnt <= waitCnt - 1'b1;
                end
                LOAD: begin
                    byteIdx <= '0;
                end
                NEXT: begin
                    if (!lastByte)     byteIdx <= byteIdx + 1'b1;
                    else if (!lastWord) addrReg <= addrReg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            bus.oMemRead <= 1'b0;
            bus.oMemAddr <= '0;
            bus.oTxStart <= 1'b0;
            bus.oTxData  <= '0;
            bus.oBusy    <= 1'b0;
            bus.oDone    <= 1'b0;
        end else begin
            bus.oMemRead <= memReadD;
            if (memReadD) bus.oMemAddr <= addrReg;
            bus.oTxStart <= txStartD;
            if (txStartD) bus.oTxData <= serByte;
            bus.oBusy    <= busyD;
            bus.oDone    <= doneD;
        end
    end

endmodule

// File: tb/tb_sample_send_ctrl.sv
// Directed bench: two controller instances (default geometry, and a small
// deep-latency one) with behavioural RAM and UART transmitter models.
module tb_sample_send_ctrl;

    logic iClock = 1'b0;
    logic iReset = 1'b1;
    always #5 iClock = ~iClock;

    sample_send_ctrl_if #(.ADDR_W(8), .DATA_W(16)) busA ();
    sample_send_ctrl_if #(.ADDR_W(4), .DATA_W(16)) busB ();

    sample_send_ctrl #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1)) dutA (
        .iClock(iClock),
        .iReset(iReset),
        .bus   (busA)
    );

    sample_send_ctrl #(.ADDR_W(4), .DATA_W(16), .MEM_LAT(3)) dutB (
        .iClock(iClock),
        .iReset(iReset),
        .bus   (busB)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM models: data presented only in the cycle it is valid, 0xDEAD otherwise.
    logic [15:0] memA [256];
    logic [15:0] memB [16];
    logic        vldA = 1'b0;
    logic [15:0] datA = '0;
    logic [2:0]  vldB = '0;
    logic [15:0] datB [3];

    always @(posedge iClock) begin
        vldA    <= busA.oMemRead;
        datA    <= memA[busA.oMemAddr];
        vldB    <= {vldB[1:0], busB.oMemRead};
        datB[0] <= memB[busB.oMemAddr];
        datB[1] <= datB[0];
        datB[2] <= datB[1];
    end
    assign busA.iMemData = vldA ? datA : 16'hDEAD;
    assign busB.iMemData = vldB[2] ? datB[2] : 16'hDEAD;

    // Transmitter models: busy for 10 cycles starting the cycle after oTxStart.
    int   txCntA = 0;
    int   txCntB = 0;
    logic stallA = 1'b0;
    always @(posedge iClock) begin
        if (busA.oTxStart)   txCntA <= 10;
        else if (txCntA != 0) txCntA <= txCntA - 1;
        if (busB.oTxStart)   txCntB <= 10;
        else if (txCntB != 0) txCntB <= txCntB - 1;
    end
    assign busA.iTxBusy = (txCntA != 0) || stallA;
    assign busB.iTxBusy = (txCntB != 0);

    int cyc = 0;
    always @(posedge iClock) cyc <= cyc + 1;

    logic [7:0] txQA[$];
    logic [7:0] txQB[$];
    int         addrQA[$];
    int         addrQB[$];
    int         doneQA[$];
    int         doneQB[$];
    int         lastStartA = -100;

    always @(negedge iClock) begin
        if (busA.oTxStart) begin
            checkEq("txGapA", 32'(cyc - lastStartA >= 3), 32'd1);
            lastStartA <= cyc;
            txQA.push_back(busA.oTxData);
        end
        if (busA.oMemRead) addrQA.push_back(int'(busA.oMemAddr));
        if (busA.oDone)    doneQA.push_back(cyc);
        if (busB.oTxStart) txQB.push_back(busB.oTxData);
        if (busB.oMemRead) addrQB.push_back(int'(busB.oMemAddr));
        if (busB.oDone)    doneQB.push_back(cyc);
    end

    task automatic clearA();
        txQA.delete();
        addrQA.delete();
        doneQA.delete();
    endtask

    task automatic startA(input int cnt);
        @(posedge iClock); #1;
        busA.iStart = 1'b1;
        busA.iCount = 9'(cnt);
        @(posedge iClock); #1;
        busA.iStart = 1'b0;
    endtask

    task automatic startB(input int cnt);
        @(posedge iClock); #1;
        busB.iStart = 1'b1;
        busB.iCount = 5'(cnt);
        @(posedge iClock); #1;
        busB.iStart = 1'b0;
    endtask

    task automatic waitDoneA(input string tag, input int budget);
        int n = 0;
        while (doneQA.size() == 0 && n < budget) begin
            @(posedge iClock);
            n++;
        end
        checkEq(tag, 32'(doneQA.size() != 0), 32'd1);
    endtask

    task automatic checkOutputsIdleA(input string tag);
        checkEq({tag, "_memRead"}, busA.oMemRead, 1'b0);
        checkEq({tag, "_memAddr"}, busA.oMemAddr, 8'h00);
        checkEq({tag, "_txStart"}, busA.oTxStart, 1'b0);
        checkEq({tag, "_txData"},  busA.oTxData,  8'h00);
        checkEq({tag, "_busy"},    busA.oBusy,    1'b0);
        checkEq({tag, "_done"},    busA.oDone,    1'b0);
    endtask

    logic [7:0] expAB [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        busA.iStart = 1'b0;
        busA.iCount = '0;
        busB.iStart = 1'b0;
        busB.iCount = '0;
        for (int unsigned i = 0; i < 256; i++) memA[i] = 16'h5A5A;
        memA[0] = 16'hA1B2;
        memA[1] = 16'hC3D4;
        for (int unsigned i = 0; i < 16; i++) memB[i] = 16'(i * 32'h0101);

        // Reset state
        repeat (3) @(posedge iClock);
        @(negedge iClock);
        checkOutputsIdleA("reset");
        checkEq("reset_B_addr", busB.oMemAddr, 4'h0);
        @(posedge iClock); #1;
        iReset = 1'b0;

        // Basic two-word run
        clearA();
        startA(2);
        waitDoneA("basic_done_seen", 400);
        repeat (20) @(posedge iClock);
        @(negedge iClock);
        checkEq("basic_nbytes", txQA.size(), 4);
        for (int i = 0; i < 4; i++)
            checkEq($sformatf("basic_byte%0d", i), txQA[i], expAB[i]);
        checkEq("basic_nreads", addrQA.size(), 2);
        checkEq("basic_addr0", addrQA[0], 0);
        checkEq("basic_addr1", addrQA[1], 1);
        checkEq("basic_ndone", doneQA.size(), 1);
        checkEq("basic_busy_after", busA.oBusy, 1'b0);

        // Zero count: oDone two cycles after iStart, oBusy for one cycle only
        clearA();
        startA(0);
        @(negedge iClock);
        checkEq("zero_c1_done", busA.oDone, 1'b0);
        checkEq("zero_c1_busy", busA.oBusy, 1'b0);
        @(negedge iClock);
        checkEq("zero_c2_done", busA.oDone, 1'b1);
        checkEq("zero_c2_busy", busA.oBusy, 1'b1);
        @(negedge iClock);
        checkEq("zero_c3_done", busA.oDone, 1'b0);
        checkEq("zero_c3_busy", busA.oBusy, 1'b0);
        repeat (5) @(posedge iClock);
        checkEq("zero_nreads", addrQA.size(), 0);
        checkEq("zero_ntx", txQA.size(), 0);
        checkEq("zero_ndone", doneQA.size(), 1);

        // Transmitter busy before start, released 50 cycles later
        clearA();
        stallA = 1'b1;
        repeat (2) @(posedge iClock);
        startA(1);
        repeat (50) @(posedge iClock);
        #1 stallA = 1'b0;
        checkEq("stall_no_early_tx", txQA.size(), 0);
        @(posedge iClock); #1;
        checkEq("stall_txstart", busA.oTxStart, 1'b1);
        checkEq("stall_txdata", busA.oTxData, 8'hA1);
        waitDoneA("stall_done_seen", 200);
        repeat (15) @(posedge iClock);
        checkEq("stall_nbytes", txQA.size(), 2);
        checkEq("stall_byte1", txQA[1], 8'hB2);
        checkEq("stall_ndone", doneQA.size(), 1);

        // Reset while waiting on the third byte
        clearA();
        startA(2);
        for (int n = 0; n < 400 && txQA.size() < 3; n++) @(posedge iClock);
        checkEq("rst_third_start_seen", 32'(txQA.size() >= 3), 32'd1);
        repeat (3) @(posedge iClock);
        #1 iReset = 1'b1;
        @(posedge iClock); #1;
        checkOutputsIdleA("rst_mid");
        iReset = 1'b0;
        repeat (20) @(posedge iClock);
        checkEq("rst_no_done", doneQA.size(), 0);
        checkEq("rst_no_more_tx", txQA.size(), 3);
        clearA();
        startA(1);
        waitDoneA("rst_restart_done_seen", 200);
        repeat (15) @(posedge iClock);
        checkEq("rst_restart_nbytes", txQA.size(), 2);
        checkEq("rst_restart_byte0", txQA[0], 8'hA1);
        checkEq("rst_restart_byte1", txQA[1], 8'hB2);
        checkEq("rst_restart_ndone", doneQA.size(), 1);

        // Second iStart while in SEND is ignored
        clearA();
        stallA = 1'b1;
        startA(2);
        repeat (10) @(posedge iClock);
        #1;
        busA.iStart = 1'b1;
        busA.iCount = 9'd1;
        @(posedge iClock); #1;
        busA.iStart = 1'b0;
        stallA = 1'b0;
        waitDoneA("ignore_done_seen", 600);
        repeat (30) @(posedge iClock);
        checkEq("ignore_nbytes", txQA.size(), 4);
        for (int i = 0; i < 4; i++)
            checkEq($sformatf("ignore_byte%0d", i), txQA[i], expAB[i]);
        checkEq("ignore_nreads", addrQA.size(), 2);
        checkEq("ignore_ndone", doneQA.size(), 1);

        // Full depth with three-cycle RAM latency
        txQB.delete();
        addrQB.delete();
        doneQB.delete();
        startB(16);
        for (int n = 0; n < 3000 && doneQB.size() == 0; n++) @(posedge iClock);
        checkEq("full_done_seen", 32'(doneQB.size() != 0), 32'd1);
        repeat (20) @(posedge iClock);
        @(negedge iClock);
        checkEq("full_nbytes", txQB.size(), 32);
        for (int i = 0; i < 32; i++)
            checkEq($sformatf("full_byte%0d", i), txQB[i], 32'(i / 2));
        checkEq("full_nreads", addrQB.size(), 16);
        for (int i = 0; i < 16; i++)
            checkEq($sformatf("full_addr%0d", i), addrQB[i], i);
        checkEq("full_addr_hold", busB.oMemAddr, 4'hF);
        checkEq("full_ndone", doneQB.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
